vector_lane_sequencer: RTL
==========================

# vector_lane_sequencer

Parametrised fork/join sequencer for the vector execute stage. It captures two V-element operand vectors, or one vector plus a broadcast scalar, and issues them in LANES-wide chunks to external per-lane ALUs. It collects the lane results back into a V-element result vector and can optionally accumulate them into an N-bit scalar reduction. It generalises the fixed 4-lane fork: any lane count, ragged final chunk with lane masking, stall, flush, explicit start/done handshake.

## Interface
- L, 8: element width (bits)
- V, 20: elements per vector
- LANES, 4: parallel lanes; NCHUNK = ceil(V/LANES)
- N, 32: scalar width
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- start_i  in  1  request to begin an operation
- mode_i  in  2  00 vector-vector, 01 vector-scalar, 10 vector-vector + sum reduction, 11 treated as 00
- vec_a_i, vec_b_i  in  V*L  operand vectors, element i at [i*L +: L]
- scalar_i  in  N  scalar operand; [L-1:0] broadcast in mode 01
- stall_i  in  1  hold the current chunk
- flush_i  in  1  abort the operation
- lane_result_i  in  LANES*L  combinational ALU results for the current chunk
- ready_o  out  1  idle; start_i is accepted
- lane_a_o, lane_b_o  out  LANES*L  chunk operands
- lane_mask_o  out  LANES  per-lane element-valid
- lane_valid_o  out  1  chunk is on the lane buses
- chunk_o  out  $clog2(NCHUNK)+1  current chunk index
- result_v_o  out  V*L  collected result vector
- result_s_o  out  N  reduction sum
- done_o  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:** ready_o=1.
  - start_i=1 and flush_i=0: capture vec_a_i and vec_b_i (or the broadcast scalar) and mode_i; clear result_v_o, result_s_o and chunk; go to RUN.
- **RUN:** lane_valid_o=1.
  - Lane k carries element e = chunk*LANES + k.
  - Lanes with e ≥ V: lane_mask_o[k]=0 and lane_a_o/lane_b_o lane k = 0.
  - At each clock edge with stall_i=0:
    - lane_result_i is written to result_v_o element e for every masked-in lane.
    - In mode 10, the zero-extended masked lane results are added to result_s_o (modulo 2^N).
    - chunk increments. After chunk NCHUNK-1 is written, the block goes to DONE.
  - stall_i=1: no write, no accumulate, chunk held, lane outputs held.
- **DONE:** done_o=1 for exactly one cycle, then return to IDLE. stall_i is ignored.
- Modes 00 and 01 leave result_s_o at 0.
- **flush_i=1** in RUN or DONE: go to IDLE on the next edge.
  - No done_o is asserted.
  - result_v_o and result_s_o keep their partial contents until the next start.
- **Priority:** RST > flush_i > stall_i > normal advance. In IDLE, flush_i=1 blocks start_i.
- start_i is ignored outside IDLE.
- result_v_o and result_s_o are stable from done_o until the next accepted start.
- Captured operands are used exclusively, so the inputs may change after the capture edge.

## Timing
- **Reset (RST low, asynchronous):**
  - State IDLE, ready_o=1.
  - done_o, lane_valid_o, lane_mask_o, lane_a_o, lane_b_o, chunk_o, result_v_o, result_s_o all 0.
- **Reset mid-operation:** the operation is abandoned immediately, with no done_o.
- **Cycle numbering**, with the capture edge as edge 0:
  - RUN occupies cycles 1..NCHUNK, plus any stall cycles.
  - done_o is high in cycle NCHUNK+1.
  - ready_o is high from cycle NCHUNK+2.
  - Defaults (NCHUNK=5): done_o in cycle 6, next start captured at the end of cycle 7.
- Lane outputs are registered/decoded from state only; they have no combinational path from inputs.
- lane_result_i must settle within the same cycle it is sampled.

## Test plan
- **Vector-vector add:**
  - Stimulus: mode 00, A[i]=i, B[i]=2i, bench adder on lanes, defaults.
  - Required: result_v_o[i]=3i; done_o single pulse in cycle 6; ready_o low in cycles 1-6.
- **Vector-scalar broadcast:**
  - Stimulus: mode 01, scalar_i=0x05, A[i]=0x10.
  - Required: lane_b_o = 0x05 on all lanes in every chunk; result_v_o[i]=0x15.
- **Ragged last chunk:**
  - Stimulus: V=10, LANES=4.
  - Required: NCHUNK=3; chunk 2 has lane_mask_o=0011 and lanes 2-3 carry 0; done_o in cycle 4; only elements 8 and 9 are written by chunk 2.
- **Reduction:**
  - Stimulus: mode 10, A[i]=200, B[i]=0, adder.
  - Required: result_s_o = 4000 (0xFA0), with no 8-bit wrap of the sum; result_v_o[i]=200.
- **Stall:**
  - Stimulus: stall_i high for 2 cycles while chunk_o=2.
  - Required: chunk_o holds at 2; done_o moves to cycle 8; results identical to the unstalled run.
- **Flush and reset:**
  - Stimulus: flush_i at chunk_o=3.
  - Required: ready_o=1 the next cycle and done_o is never asserted. A following start_i completes normally.
  - Stimulus: RST low mid-RUN.
  - Required: all outputs at reset values immediately.

Source files
------------

// File: rtl/vector_lane_sequencer.sv
// Fork/join sequencer: issues two captured operand vectors to external lane ALUs
// LANES elements at a time and gathers the lane results, optionally summing them.
module vector_lane_sequencer #(
  parameter int L     = 8,
  parameter int V     = 20,
  parameter int LANES = 4,
  parameter int N     = 32,
  localparam int NCHUNK = (V + LANES - 1) / LANES,
  localparam int CW     = $clog2(NCHUNK) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic [V*L-1:0]     vec_a_i,
  input  logic [V*L-1:0]     vec_b_i,
  input  logic [N-1:0]       scalar_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [LANES*L-1:0] lane_result_i,
  output logic               ready_o,
  output logic [LANES*L-1:0] lane_a_o,
  output logic [LANES*L-1:0] lane_b_o,
  output logic [LANES-1:0]   lane_mask_o,
  output logic               lane_valid_o,
  output logic [CW-1:0]      chunk_o,
  output logic [V*L-1:0]     result_v_o,
  output logic [N-1:0]       result_s_o,
  output logic               done_o
);

  localparam int PADW = NCHUNK * LANES;
  localparam logic [PADW-1:0] ELEM_VALID = PADW'({V{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [V*L-1:0]      op_a;
  logic [V*L-1:0]      op_b;
  logic                reduce;
  logic [CW-1:0]       chunk;
  logic [PADW*L-1:0]   pad_a;
  logic [PADW*L-1:0]   pad_b;
  logic [N-1:0]        lane_sum;
  logic                unused_scalar;

  // Zero padding past element V-1 makes the ragged last chunk drive zeros on its spare lanes.
  assign pad_a   = (PADW*L)'(op_a);
  assign pad_b   = (PADW*L)'(op_b);
  assign chunk_o = chunk;
  assign unused_scalar = ^scalar_i[N-1:L];

  always_comb begin
    lane_a_o    = '0;
    lane_b_o    = '0;
    lane_mask_o = '0;
    if (state == RUN) begin
      for (int c = 0; c < NCHUNK; c++) begin
        if (chunk == CW'(c)) begin
          lane_a_o    = pad_a[c*LANES*L +: LANES*L];
          lane_b_o    = pad_b[c*LANES*L +: LANES*L];
          lane_mask_o = ELEM_VALID[c*LANES +: LANES];
        end
      end
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_mask_o[k]) lane_sum = lane_sum + N'(lane_result_i[k*L +: L]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ready_o      <= 1'b1;
      lane_valid_o <= 1'b0;
      done_o       <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      reduce       <= 1'b0;
      chunk        <= '0;
      result_v_o   <= '0;
      result_s_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            op_a         <= vec_a_i;
            op_b         <= (mode_i == 2'b01) ? {V{scalar_i[L-1:0]}} : vec_b_i;
            reduce       <= (mode_i == 2'b10);
            chunk        <= '0;
            result_v_o   <= '0;
            result_s_o   <= '0;
            state        <= RUN;
            ready_o      <= 1'b0;
            lane_valid_o <= 1'b1;
          end
        end
        RUN: begin
          if (flush_i) begin
            state        <= IDLE;
            ready_o      <= 1'b1;
            lane_valid_o <= 1'b0;
          end else if (!stall_i) begin
            for (int e = 0; e < V; e++) begin
              if (chunk == CW'(e / LANES))
                result_v_o[e*L +: L] <= lane_result_i[(e % LANES)*L +: L];
            end
            if (reduce) result_s_o <= result_s_o + lane_sum;
            chunk <= chunk + CW'(1);
            if (chunk == CW'(NCHUNK - 1)) begin
              state        <= DONE;
              lane_valid_o <= 1'b0;
              done_o       <= 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          done_o  <= 1'b0;
          ready_o <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          ready_o      <= 1'b1;
          lane_valid_o <= 1'b0;
          done_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule
